// File: rtl/alu_nibble_seq.sv
// Nibble-serial sequencer that runs NIBBLES*4-bit 74181 operations through a single 4-bit slice,
// least significant nibble first, with request/response valid/ready handshakes.
module alu_nibble_seq #(
   parameter int unsigned NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [4*NIBBLES-1:0] a_in,
   input  logic [4*NIBBLES-1:0] b_in,
   input  logic [3:0]           s_in,
   input  logic                 m_in,
   input  logic                 cn_in,
   output logic                 busy,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [4*NIBBLES-1:0] f_out,
   output logic                 cn_out,
   output logic                 eq_out,
   output logic                 zero_out
);

   localparam int unsigned W  = 4 * NIBBLES;
   localparam int unsigned IW = $clog2(NIBBLES);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state_q;
   logic [IW-1:0] idx_q;
   logic [W-1:0]  a_q, b_q, res_q, f_q;
   logic [3:0]    s_q;
   logic          m_q, carry_n_q, eq_acc_q;
   logic          cn_q, eq_q, zero_q, rsp_valid_q;

   logic [3:0]    slice_e, slice_d, slice_f;
   logic [4:0]    slice_c;
   logic [W-1:0]  res_d;

   // 74181 slice, active-high data; slice_c is the active-high internal carry chain.
   always_comb begin
      slice_e = ~((a_q[3:0] & b_q[3:0] & {4{s_q[3]}}) |
                  (a_q[3:0] & ~b_q[3:0] & {4{s_q[2]}}));
      slice_d = ~(a_q[3:0] | (b_q[3:0] & {4{s_q[0]}}) | (~b_q[3:0] & {4{s_q[1]}}));
      slice_c = '0;
      slice_c[0] = ~carry_n_q;
      for (int unsigned i = 0; i < 4; i++) begin
         slice_c[i+1] = ~slice_e[i] | (~slice_d[i] & slice_c[i]);
      end
      slice_f = slice_e ^ slice_d ^ (slice_c[3:0] | {4{m_q}});
      res_d   = {slice_f, res_q[W-1:4]};
   end

   // Operands shift down one nibble per RUN edge and results shift in from the top,
   // so nibble idx is always at the bottom of a_q/b_q; after NIBBLES edges res_d is aligned.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         s_q         <= '0;
         m_q         <= 1'b0;
         carry_n_q   <= 1'b1;
         eq_acc_q    <= 1'b1;
         res_q       <= '0;
         f_q         <= '0;
         cn_q        <= 1'b1;
         eq_q        <= 1'b0;
         zero_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  a_q       <= a_in;
                  b_q       <= b_in;
                  s_q       <= s_in;
                  m_q       <= m_in;
                  carry_n_q <= cn_in;
                  eq_acc_q  <= 1'b1;
                  idx_q     <= '0;
                  state_q   <= RUN;
               end
            end
            RUN: begin
               a_q       <= a_q >> 4;
               b_q       <= b_q >> 4;
               res_q     <= res_d;
               carry_n_q <= ~slice_c[4];
               eq_acc_q  <= eq_acc_q & (&slice_f);
               idx_q     <= idx_q + 1'b1;
               if (idx_q == IW'(NIBBLES - 1)) begin
                  idx_q       <= '0;
                  f_q         <= res_d;
                  cn_q        <= m_q | ~slice_c[4];
                  eq_q        <= eq_acc_q & (&slice_f);
                  zero_q      <= (res_d == '0);
                  rsp_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign rsp_valid = rsp_valid_q;
   assign f_out     = f_q;
   assign cn_out    = cn_q;
   assign eq_out    = eq_q;
   assign zero_out  = zero_q;

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Self-checking bench for alu_nibble_seq: vector table plus scoreboard, with
// backpressure and mid-operation reset sequences.
module tb_alu_nibble_seq;

   localparam int unsigned NIB = 4;
   localparam int unsigned W   = 4 * NIB;

   typedef struct {
      logic [W-1:0] f;
      logic         cn;
      logic         eq;
      logic         zero;
   } exp_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [3:0]   s;
      logic         m;
      logic         cn;
      exp_t         e;
   } vec_t;

   logic         clk, rst_n;
   logic         req_valid, req_ready;
   logic [W-1:0] a_in, b_in;
   logic [3:0]   s_in;
   logic         m_in, cn_in;
   logic         busy, rsp_valid, rsp_ready;
   logic [W-1:0] f_out;
   logic         cn_out, eq_out, zero_out;

   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];

   alu_nibble_seq #(.NIBBLES(NIB)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .a_in     (a_in),
      .b_in     (b_in),
      .s_in     (s_in),
      .m_in     (m_in),
      .cn_in    (cn_in),
      .busy     (busy),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .f_out    (f_out),
      .cn_out   (cn_out),
      .eq_out   (eq_out),
      .zero_out (zero_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   // Arithmetic reference for add (S=1001) and subtract (S=0110) on the full width.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [3:0] s, input logic cn);
      logic [W:0] sum;
      exp_t r;
      if (s == 4'b1001) sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ~cn};
      else              sum = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, ~cn};
      r.f    = sum[W-1:0];
      r.cn   = ~sum[W];
      r.eq   = &sum[W-1:0];
      r.zero = (sum[W-1:0] == '0);
      return r;
   endfunction

   task automatic run_op(input vec_t v, input int hold);
      exp_t e;
      int   lat;
      logic [W-1:0] f_hold;
      @(negedge clk);
      chk("req_ready_before_accept", 32'(req_ready), 32'd1);
      a_in = v.a; b_in = v.b; s_in = v.s; m_in = v.m; cn_in = v.cn;
      req_valid = 1'b1;
      sb.push_back(v.e);
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         @(posedge clk); lat++; #1;
      end
      chk("latency", 32'(lat), 32'(NIB));
      f_hold = f_out;
      for (int k = 0; k < hold; k++) begin
         req_valid = ~req_valid;
         a_in = W'($urandom);
         @(posedge clk); #1;
         chk("bp_f_stable", 32'(f_out), 32'(f_hold));
         chk("bp_req_ready", 32'(req_ready), 32'd0);
         chk("bp_busy", 32'(busy), 32'd1);
         chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      end
      if (sb.size() == 0) begin
         chk("scoreboard_nonempty", 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         chk("f_out", 32'(f_out), 32'(e.f));
         chk("cn_out", 32'(cn_out), 32'(e.cn));
         chk("eq_out", 32'(eq_out), 32'(e.eq));
         chk("zero_out", 32'(zero_out), 32'(e.zero));
      end
      rsp_ready = 1'b1;
      if (hold > 0) req_valid = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("post_hs_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("post_hs_busy", 32'(busy), 32'd0);
      chk("post_hs_req_ready", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_f_out"}, 32'(f_out), 32'd0);
      chk({tag, "_cn_out"}, 32'(cn_out), 32'd1);
      chk({tag, "_eq_out"}, 32'(eq_out), 32'd0);
      chk({tag, "_zero_out"}, 32'(zero_out), 32'd0);
   endtask

   vec_t tbl[10];
   vec_t v;

   initial begin
      tbl[0] = '{16'h12FF, 16'h0001, 4'b1001, 1'b0, 1'b1, '{16'h1300, 1'b1, 1'b0, 1'b0}};
      tbl[1] = '{16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, '{16'h0000, 1'b0, 1'b0, 1'b1}};
      tbl[2] = '{16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, '{16'h0001, 1'b0, 1'b0, 1'b0}};
      tbl[3] = '{16'h5A5B, 16'h5A5A, 4'b0110, 1'b0, 1'b1, '{16'h0000, 1'b0, 1'b0, 1'b1}};
      tbl[4] = '{16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b0, '{16'h0FF0, 1'b1, 1'b0, 1'b0}};
      tbl[5] = '{16'hF0F0, 16'hFF00, 4'b1011, 1'b1, 1'b0, '{16'hF000, 1'b1, 1'b0, 1'b0}};
      tbl[6] = '{16'hF0F0, 16'hFF00, 4'b1110, 1'b1, 1'b0, '{16'hFFF0, 1'b1, 1'b0, 1'b0}};
      tbl[7] = '{16'h1234, 16'h0000, 4'b0000, 1'b1, 1'b1, '{16'hEDCB, 1'b1, 1'b0, 1'b0}};
      tbl[8] = '{16'h1234, 16'hABCD, 4'b1100, 1'b1, 1'b0, '{16'hFFFF, 1'b1, 1'b1, 1'b0}};
      tbl[9] = '{16'h5A5A, 16'h5A5A, 4'b0110, 1'b0, 1'b1, '{16'hFFFF, 1'b1, 1'b1, 1'b0}};

      rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
      a_in = '0; b_in = '0; s_in = '0; m_in = 1'b0; cn_in = 1'b1;
      #12;
      chk_reset_vals("reset");
      chk("reset_req_ready", 32'(req_ready), 32'd1);
      @(negedge clk); rst_n = 1'b1;

      for (int i = 0; i < 10; i++) run_op(tbl[i], 0);

      for (int i = 0; i < 8; i++) begin
         v.a  = W'($urandom);
         v.b  = W'($urandom);
         v.s  = (i % 2 == 0) ? 4'b1001 : 4'b0110;
         v.m  = 1'b0;
         v.cn = 1'(i / 2);
         v.e  = model(v.a, v.b, v.s, v.cn);
         run_op(v, 0);
      end

      // Backpressure in DONE, then a fresh request.
      v = tbl[0];
      run_op(v, 5);
      v.a = 16'h0F0F; v.b = 16'h00F1; v.s = 4'b1001; v.m = 1'b0; v.cn = 1'b1;
      v.e = model(v.a, v.b, v.s, v.cn);
      run_op(v, 0);

      // Leave non-reset outputs behind, then abandon an operation mid-RUN.
      run_op(tbl[9], 0);
      @(negedge clk);
      a_in = 16'h1111; b_in = 16'h0001; s_in = 4'b1001; m_in = 1'b0; cn_in = 1'b0;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("midrun_reset");
      @(negedge clk); rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("no_rsp_after_abort", 32'(rsp_valid), 32'd0);
      chk("idle_after_abort", 32'(busy), 32'd0);
      v = '{16'h0003, 16'h0004, 4'b1001, 1'b0, 1'b1, '{16'h0007, 1'b1, 1'b0, 1'b0}};
      run_op(v, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
